// File: rtl/demux_router.sv
// demux_router
//   Registered 1-to-N demultiplexer. A word and its destination channel are
//   taken over a valid/ready handshake, held in a register, and presented
//   on the addressed output lane until that consumer accepts it.
//
//   State | meaning
//   IDLE  | hold register empty, ready for a new word
//   HOLD  | word held, presented on lane sel until out_ready[sel]
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input word/address valid
//   in_ready   block can accept a word this cycle
//   in_data    input word
//   in_addr    destination channel index
//   out_valid  per-channel valid (bit k = channel k)
//   out_ready  per-channel ready from the consumers
//   out_data   flattened lanes, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   err        one-cycle pulse when an out-of-range address is dropped
//   err_count  saturating count of dropped words
//
// Optional build macro: DEMUX_ROUTER_PIPE_EN
//   When defined, HOLD accepts a new word in the same cycle the held word
//   is taken, giving one word per cycle.
module demux_router #(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUTS    = 2,
    parameter int ADDR_WIDTH = $clog2(OUTPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    output logic [OUTPUTS-1:0]            out_valid,
    input  logic [OUTPUTS-1:0]            out_ready,
    output logic [OUTPUTS*DATA_WIDTH-1:0] out_data,
    output logic                          err,
    output logic [7:0]                    err_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One extra bit so the compare also works when OUTPUTS is a power of 2.
    localparam logic [ADDR_WIDTH:0] NUM_OUT = (ADDR_WIDTH+1)'(OUTPUTS);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [ADDR_WIDTH-1:0]   sel;
    logic                    sel_ready;
    logic                    addr_ok;
    logic                    accept;
    logic                    load;
    logic                    drop;
    logic                    xfer;

    // Ready of the selected consumer; decoded by loop so an unused sel code
    // (non power-of-2 OUTPUTS) never indexes past the vector.
    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < OUTPUTS; k++) begin
            if (sel == ADDR_WIDTH'(k)) begin
                sel_ready = out_ready[k];
            end
        end
    end

    assign addr_ok = ({1'b0, in_addr} < NUM_OUT);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef DEMUX_ROUTER_PIPE_EN
            else begin
                in_ready = sel_ready;
            end
`endif
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = accept & addr_ok;
    assign drop   = accept & ~addr_ok;
    assign xfer   = (state == HOLD) & sel_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // load can only be set here when the pipelined build lets
                // HOLD accept; otherwise a completed transfer returns to IDLE.
                if (xfer) begin
                    state_nxt = load ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold register and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            sel       <= '0;
            err       <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (load) begin
                hold_data <= in_data;
                sel       <= in_addr;
            end
            err <= drop;
            if (drop && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

    // Output logic: decoded only from registered state, sel and hold_data.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        if (state == HOLD) begin
            for (int k = 0; k < OUTPUTS; k++) begin
                if (sel == ADDR_WIDTH'(k)) begin
                    out_valid[k]                           = 1'b1;
                    out_data[k*DATA_WIDTH +: DATA_WIDTH]   = hold_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router
//   Scoreboard bench for demux_router with OUTPUTS=3, so both in-range
//   routing and the out-of-range drop path are reachable on one instance.
//   Accepted in-range words push an expected (channel, data) entry; the
//   negedge monitor pops and compares on every completed output handshake.
module tb_demux_router;

    localparam int DW = 32;
    localparam int NO = 3;
    localparam int AW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [AW-1:0]  in_addr;
    logic [NO-1:0]  out_valid;
    logic [NO-1:0]  out_ready;
    logic [NO*DW-1:0] out_data;
    logic           err;
    logic [7:0]     err_count;

    typedef struct {
        logic [AW-1:0] ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   pops     = 0;
    int   err_seen = 0;

    demux_router #(
        .DATA_WIDTH(DW),
        .OUTPUTS   (NO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_addr  (in_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err      (err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] lane(input int k);
        return out_data[k*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one word; holds it until the handshake edge (bounded).
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   g;
        logic rdy;
        exp_t e;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        g   = 0;
        rdy = 1'b0;
        while (!rdy && g < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            g++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for addr %0d", a);
        end else if (int'(a) < NO) begin
            e.ch   = a;
            e.data = d;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    // Monitor: compares every completed output transfer against the scoreboard.
    always @(negedge clk) begin : mon
        int   ch;
        exp_t e;
        if (!rst) begin
            if (err) err_seen++;
            if (out_valid != '0) begin
                ch = 0;
                for (int k = 0; k < NO; k++) if (out_valid[k]) ch = k;
                check("onehot", 64'($onehot(out_valid)), 64'(1));
                for (int k = 0; k < NO; k++) begin
                    if (k != ch) check("idle_lane_zero", 64'(lane(k)), 64'(0));
                end
                if (out_ready[ch]) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL route_unexpected: channel %0d data %0h, expected nothing", ch, lane(ch));
                    end else begin
                        e = sb.pop_front();
                        check("route_ch", 64'(ch), 64'(e.ch));
                        check("route_data", 64'(lane(ch)), 64'(e.data));
                    end
                    pops++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        int g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        out_ready = '0;

        // Reset values
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data[63:0]), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk) #1;

        // Basic route to channel 2
        out_ready = 3'b111;
        send(2'd2, 32'h1234_5678);
        @(negedge clk);
        check("basic_valid", 64'(out_valid), 64'(3'b100));
        check("basic_lane2", 64'(lane(2)), 64'(32'h1234_5678));
        check("basic_lane0", 64'(lane(0)), 64'(0));
`ifdef DEMUX_ROUTER_PIPE_EN
        check("basic_in_ready", 64'(in_ready), 64'(1));
`else
        check("basic_in_ready", 64'(in_ready), 64'(0));
`endif
        @(negedge clk);
        check("basic_one_cycle", 64'(out_valid), 64'(0));
        @(posedge clk) #1;

        // Backpressure: channel 1 not ready for 5 cycles
        out_ready = 3'b101;
        send(2'd1, 32'hA5A5_A5A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'(3'b010));
            check("bp_lane1", 64'(lane(1)), 64'(32'hA5A5_A5A5));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk) #1 out_ready = 3'b111;
        @(negedge clk);
        check("bp_valid_6th", 64'(out_valid), 64'(3'b010));
        check("bp_lane1_6th", 64'(lane(1)), 64'(32'hA5A5_A5A5));
        @(negedge clk);
        check("bp_done", 64'(out_valid), 64'(0));
        @(posedge clk) #1;

        // Ready on a non-selected channel must be ignored
        out_ready = 3'b010;
        send(2'd0, 32'hCAFE_0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrong_ready_hold", 64'(out_valid), 64'(3'b001));
        end
        @(posedge clk) #1 out_ready = 3'b001;
        @(negedge clk);
        check("wrong_ready_last", 64'(out_valid), 64'(3'b001));
        @(negedge clk);
        check("wrong_ready_done", 64'(out_valid), 64'(0));
        @(posedge clk) #1;

        // Out-of-range address 3 is dropped
        out_ready = 3'b111;
        send(2'd3, 32'h0BAD_0BAD);
        @(negedge clk);
        check("oor_err_pulse", 64'(err), 64'(1));
        check("oor_no_valid", 64'(out_valid), 64'(0));
        check("oor_count1", 64'(err_count), 64'(1));
        @(negedge clk);
        check("oor_err_clear", 64'(err), 64'(0));
        check("oor_count1_hold", 64'(err_count), 64'(1));
        @(posedge clk) #1;
        for (int i = 0; i < 299; i++) send(2'd3, 32'(i));
        @(negedge clk);
        check("oor_saturate", 64'(err_count), 64'(255));
        @(negedge clk);
        check("oor_err_cycles", 64'(err_seen), 64'(300));
        check("oor_err_low", 64'(err), 64'(0));
        @(posedge clk) #1;

        // Throughput with always-ready consumers
        out_ready = 3'b111;
        base = pops;
        t0   = cyc;
        for (int i = 0; i < 8; i++) send(2'(i % 2), 32'h1000_0000 + 32'(i));
        g = 0;
        while (pops < base + 8 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("tput_count", 64'(pops - base), 64'(8));
`ifdef DEMUX_ROUTER_PIPE_EN
        check("tput_cycles", 64'(cyc - t0), 64'(9));
`else
        check("tput_cycles", 64'(cyc - t0), 64'(16));
`endif

        // Async reset in HOLD discards the held word
        @(posedge clk) #1;
        out_ready = 3'b000;
        send(2'd1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("hold_before_rst", 64'(out_valid), 64'(3'b010));
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_lane1", 64'(lane(1)), 64'(0));
        check("arst_err_count", 64'(err_count), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(0));
        sb.delete();
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        check("arst_release_in_ready", 64'(in_ready), 64'(1));
        check("arst_release_valid", 64'(out_valid), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-N demultiplexer: the write-side counterpart of the core's read-side N-to-1 selector.
- Accepts one data word plus a destination address over a valid/ready handshake and holds it in an internal register.
- Presents the word on the addressed output channel only, until that channel accepts it.
- Used in the core to steer results (ALU/load writeback, peripheral writes) to one of several consumers.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- OUTPUTS, 2, number of output channels; must be >= 2.
- ADDR_WIDTH, clog2(OUTPUTS), width of the destination address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word and address are valid.
- in_ready  output  1  block can accept an input word this cycle.
- in_data  input  DATA_WIDTH  input word.
- in_addr  input  ADDR_WIDTH  destination channel index.
- out_valid  output  OUTPUTS  per-channel valid; bit k belongs to channel k.
- out_ready  input  OUTPUTS  per-channel ready from the consumers.
- out_data  output  OUTPUTS*DATA_WIDTH  flattened lanes; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- err  output  1  one-cycle pulse when an out-of-range address is dropped.
- err_count  output  8  saturating count of dropped words.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; hold register and address are cleared.
  - out_valid=0, all out_data lanes=0, err=0, err_count=0.
  - in_ready=0 while rst is high.
- State IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid & in_ready with in_addr < OUTPUTS: capture in_data and in_addr, then go to HOLD.
  - On in_valid & in_ready with in_addr >= OUTPUTS (only possible when OUTPUTS is not a power of 2):
    - The word is dropped and the state stays IDLE.
    - err=1 on the next cycle for exactly one cycle.
    - err_count increments and saturates at 255.
- State HOLD:
  - out_valid[sel]=1; all other out_valid bits are 0.
  - Lane sel carries the held word; all other lanes are driven 0.
  - in_ready=0.
  - When out_ready[sel]=1 the transfer completes on that edge and the state returns to IDLE.
  - out_ready on non-selected channels is ignored.
  - The held word and sel stay stable until the transfer completes; there is no timeout.
- Latency and throughput:
  - An input accepted at edge N is visible as out_valid at cycle N+1.
  - Throughput is one word per 2 cycles with a permanently ready consumer.
- Outputs are registered: out_valid and out_data are driven from flops, never combinationally from in_*.
- Async reset in HOLD discards the held word; no output handshake completes on that edge.
- Values of in_data and in_addr while in_valid=0 have no effect.

Optional Feature:
- Macro DEMUX_ROUTER_PIPE_EN.
- Defined:
  - In HOLD, in_ready = out_ready[sel].
  - A simultaneous output transfer and input acceptance with a valid address reloads the hold register; the state stays HOLD, giving one word per cycle.
  - A simultaneous transfer and an out-of-range input: drop the input, pulse err, go to IDLE.
- Not defined: in_ready=0 in HOLD exactly as described in Behaviour.

Test Plan:
- Reset: assert rst mid-HOLD holding 0xDEADBEEF for channel 1 -> out_valid=00, all lanes 0, err_count=0 immediately (async); in_ready=1 on the first cycle after release.
- Basic route: OUTPUTS=4; send 0x12345678 to addr 2 with out_ready=1111 ->
  - out_valid=0100 for exactly one cycle, starting the cycle after acceptance.
  - lane 2=0x12345678, other lanes 0.
  - in_ready=0 during that cycle.
- Backpressure: send 0xA5A5A5A5 to addr 1 with out_ready=1101 for 5 cycles, then 1111 ->
  - out_valid=0010 and the lane stays stable for 6 cycles, completing on the 6th.
  - in_ready stays 0 throughout.
- Out-of-range: OUTPUTS=3; send to addr 3 -> no out_valid, err pulses once, err_count=1. Repeat 300 times -> err_count=255.
- Throughput: 8 back-to-back inputs to alternating addrs 0/1, consumers always ready -> 8 outputs in order, in 16 cycles without the macro and in 9 cycles with DEMUX_ROUTER_PIPE_EN.
- Ignore wrong ready: HOLD on channel 0 with out_ready=0010 -> no completion; the word stays held until out_ready[0]=1.
